// File: rtl/retire_ctrl_if.sv
// ---------------------------------------------------------------------------
// retire_ctrl_if
// Bundle between the retire controller and the ROB head window, store queue
// and backend.
//   head_valid/complete/mispredict/is_store/halt : N-slot ROB head window,
//                                                  slot 0 is the oldest
//   sq_commit_ready    : store queue can take one store commit this cycle
//   num_retiring       : entries the ROB frees this cycle
//   store_commit       : a store retires this cycle
//   flush              : one-cycle pipeline flush pulse
//   tail_restore_valid : ROB tail restore strobe, coincident with flush
//   tail_restore       : ROB index directly after the mispredicted branch
//   head_ptr           : controller's copy of the ROB head
//   halted             : sticky halt indication
//   retired_count      : saturating count of retired instructions
// The master modport is the controller; the slave modport is the ROB side.
// ---------------------------------------------------------------------------
interface retire_ctrl_if #(
    parameter int N      = 3,
    parameter int ROB_SZ = 32
);
    localparam int CW = $clog2(N + 1);
    localparam int PW = $clog2(ROB_SZ);

    logic [N-1:0]  head_valid;
    logic [N-1:0]  head_complete;
    logic [N-1:0]  head_mispredict;
    logic [N-1:0]  head_is_store;
    logic [N-1:0]  head_halt;
    logic          sq_commit_ready;

    logic [CW-1:0] num_retiring;
    logic          store_commit;
    logic          flush;
    logic          tail_restore_valid;
    logic [PW-1:0] tail_restore;
    logic [PW-1:0] head_ptr;
    logic          halted;
    logic [31:0]   retired_count;

    modport master (
        input  head_valid, head_complete, head_mispredict, head_is_store,
               head_halt, sq_commit_ready,
        output num_retiring, store_commit, flush, tail_restore_valid,
               tail_restore, head_ptr, halted, retired_count
    );

    modport slave (
        output head_valid, head_complete, head_mispredict, head_is_store,
               head_halt, sq_commit_ready,
        input  num_retiring, store_commit, flush, tail_restore_valid,
               tail_restore, head_ptr, halted, retired_count
    );
endinterface

// File: rtl/retire_ctrl.sv
// ---------------------------------------------------------------------------
// retire_ctrl
// Retire-stage controller. Each cycle it scans the N oldest ROB entries and
// decides how many retire (at most one store per cycle, gated by the store
// queue). A retiring mispredicted branch triggers a registered flush pulse
// with a ROB tail restore, followed by RECOVER_CYCLES cycles with retirement
// frozen. A retiring halt stops retirement until reset.
// Ports:
//   clock : system clock
//   reset : asynchronous, active-low reset
//   bus   : retire_ctrl_if.master (head window in, retire/flush/status out)
// ---------------------------------------------------------------------------
module retire_ctrl #(
    parameter int N              = 3,
    parameter int ROB_SZ         = 32,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic           clock,
    input  logic           reset,
    retire_ctrl_if.master  bus
);
    localparam int CW  = $clog2(N + 1);
    localparam int PW  = $clog2(ROB_SZ);
    // Counter only has to hold RECOVER_CYCLES-1.
    localparam int RCW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_RECOVER,
        ST_HALTED
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [RCW-1:0] r_rec_cnt;
    logic [RCW-1:0] w_rec_cnt_next;
    logic [PW-1:0]  r_head_ptr;
    logic [PW-1:0]  r_tail_restore;
    logic           r_flush;
    logic           r_halted;
    logic [31:0]    r_retired_count;

    logic [N-1:0]   w_slot_done;
    logic [CW-1:0]  w_scan_cnt;
    logic           w_scan_store;
    logic           w_scan_mis;
    logic           w_scan_halt;
    logic [PW-1:0]  w_scan_k;
    logic           w_stop;
    logic [CW-1:0]  w_num;
    logic           w_store;
    logic [32:0]    w_count_sum;

    // A slot is a retirement candidate once it is valid and complete.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slot
            assign w_slot_done[gi] = bus.head_valid[gi] & bus.head_complete[gi];
        end
    endgenerate

    // In-order scan of the head window. The scan stops at the first slot
    // that cannot retire, and after (inclusive of) the first retiring halt
    // or mispredict. A second store is blocked because only one store
    // commit port exists. If one slot carries both halt and mispredict,
    // the halt takes effect: the program is stopping anyway.
    always_comb begin
        w_scan_cnt   = '0;
        w_scan_store = 1'b0;
        w_scan_mis   = 1'b0;
        w_scan_halt  = 1'b0;
        w_scan_k     = '0;
        w_stop       = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!w_stop) begin
                if (w_slot_done[i] &&
                    (!bus.head_is_store[i] || (bus.sq_commit_ready && !w_scan_store))) begin
                    w_scan_cnt = w_scan_cnt + CW'(1);
                    if (bus.head_is_store[i]) begin
                        w_scan_store = 1'b1;
                    end
                    if (bus.head_halt[i]) begin
                        w_scan_halt = 1'b1;
                        w_stop      = 1'b1;
                    end else if (bus.head_mispredict[i]) begin
                        w_scan_mis = 1'b1;
                        w_scan_k   = PW'(i);
                        w_stop     = 1'b1;
                    end
                end else begin
                    w_stop = 1'b1;
                end
            end
        end
    end

    // Next-state and retirement outputs. Only RUN lets the scan through.
    always_comb begin
        w_state_next   = r_state;
        w_rec_cnt_next = r_rec_cnt;
        w_num          = '0;
        w_store        = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_num   = w_scan_cnt;
                w_store = w_scan_store;
                if (w_scan_halt) begin
                    w_state_next = ST_HALTED;
                end else if (w_scan_mis) begin
                    w_state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                w_state_next   = ST_RECOVER;
                w_rec_cnt_next = RCW'(RECOVER_CYCLES - 1);
            end
            ST_RECOVER: begin
                if (r_rec_cnt == '0) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_rec_cnt_next = r_rec_cnt - RCW'(1);
                end
            end
            ST_HALTED: begin
                w_state_next = ST_HALTED;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    // Extra top bit detects wrap so the count can saturate.
    assign w_count_sum = {1'b0, r_retired_count} + 33'(w_num);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state         <= ST_RUN;
            r_rec_cnt       <= '0;
            r_head_ptr      <= '0;
            r_tail_restore  <= '0;
            r_flush         <= 1'b0;
            r_halted        <= 1'b0;
            r_retired_count <= '0;
        end else begin
            r_state         <= w_state_next;
            r_rec_cnt       <= w_rec_cnt_next;
            // ROB_SZ is a power of two, so truncation gives the wrap.
            r_head_ptr      <= r_head_ptr + PW'(w_num);
            r_retired_count <= w_count_sum[32] ? 32'hFFFF_FFFF : w_count_sum[31:0];
            // Flush and halted are registered images of the state being
            // entered, so they line up exactly with FLUSH / HALTED.
            r_flush         <= (w_state_next == ST_FLUSH);
            r_halted        <= (w_state_next == ST_HALTED);
            if (w_state_next == ST_FLUSH) begin
                r_tail_restore <= r_head_ptr + w_scan_k + PW'(1);
            end
        end
    end

    assign bus.num_retiring       = w_num;
    assign bus.store_commit       = w_store;
    assign bus.flush              = r_flush;
    assign bus.tail_restore_valid = r_flush;
    assign bus.tail_restore       = r_tail_restore;
    assign bus.head_ptr           = r_head_ptr;
    assign bus.halted             = r_halted;
    assign bus.retired_count      = r_retired_count;

endmodule

// File: tb/tb_retire_ctrl.sv
// ---------------------------------------------------------------------------
// tb_retire_ctrl
// Directed scenarios followed by random head windows, all compared against a
// behavioural model that tracks head position, retired total, a count of
// frozen cycles after a mispredict, and a halted flag.
// ---------------------------------------------------------------------------
module tb_retire_ctrl;
    localparam int N      = 3;
    localparam int ROB_SZ = 32;
    localparam int RC     = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    retire_ctrl_if #(.N(N), .ROB_SZ(ROB_SZ)) bus ();

    retire_ctrl #(.N(N), .ROB_SZ(ROB_SZ), .RECOVER_CYCLES(RC)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int     m_head;
    longint m_count;
    bit     m_halted;
    bit     m_flush;
    int     m_frozen;   // remaining cycles with no retirement after a mispredict
    int     m_tail;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_head   = 0;
        m_count  = 0;
        m_halted = 0;
        m_flush  = 0;
        m_frozen = 0;
        m_tail   = 0;
    endtask

    // Which slots retire this cycle, straight from the retirement rules.
    task automatic model_scan(output int n, output bit st, output bit mis,
                              output bit hlt, output int k);
        n = 0; st = 0; mis = 0; hlt = 0; k = 0;
        if (m_halted || m_frozen > 0) return;
        for (int i = 0; i < N; i++) begin
            if (!(bus.head_valid[i] && bus.head_complete[i])) break;
            if (bus.head_is_store[i] && (!bus.sq_commit_ready || st)) break;
            n++;
            if (bus.head_is_store[i]) st = 1;
            if (bus.head_halt[i]) begin hlt = 1; break; end
            if (bus.head_mispredict[i]) begin mis = 1; k = i; break; end
        end
    endtask

    // One clock: drive the window after the falling edge, check everything,
    // then advance the model across the next rising edge.
    task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] c,
                         input logic [N-1:0] m, input logic [N-1:0] s,
                         input logic [N-1:0] h, input logic rdy,
                         input string tag, input int exp_num);
        int n, k;
        bit st, mis, hlt;
        @(negedge clock);
        bus.head_valid      = v;
        bus.head_complete   = c;
        bus.head_mispredict = m;
        bus.head_is_store   = s;
        bus.head_halt       = h;
        bus.sq_commit_ready = rdy;
        #1;
        model_scan(n, st, mis, hlt, k);
        check_val({tag, ".num"},   64'(bus.num_retiring), 64'(n));
        check_val({tag, ".store"}, 64'(bus.store_commit), 64'(st));
        check_val({tag, ".flush"}, 64'(bus.flush), 64'(m_flush));
        check_val({tag, ".trv"},   64'(bus.tail_restore_valid), 64'(m_flush));
        if (m_flush) check_val({tag, ".tail"}, 64'(bus.tail_restore), 64'(m_tail));
        check_val({tag, ".head"},  64'(bus.head_ptr), 64'(m_head));
        check_val({tag, ".halt"},  64'(bus.halted), 64'(m_halted));
        check_val({tag, ".cnt"},   64'(bus.retired_count), 64'(m_count));
        if (exp_num >= 0) check_val({tag, ".tp"}, 64'(bus.num_retiring), 64'(exp_num));
        if (mis && !hlt) m_tail = (m_head + k + 1) % ROB_SZ;
        m_head  = (m_head + n) % ROB_SZ;
        m_count = m_count + n;
        if (m_count > 64'hFFFF_FFFF) m_count = 64'hFFFF_FFFF;
        m_flush = 0;
        if (m_frozen > 0) m_frozen--;
        if (hlt) m_halted = 1;
        else if (mis) begin
            m_flush  = 1;
            m_frozen = 1 + RC;
        end
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset(input string tag);
        bus.head_valid      = '0;
        bus.head_complete   = '0;
        bus.head_mispredict = '0;
        bus.head_is_store   = '0;
        bus.head_halt       = '0;
        bus.sq_commit_ready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_val({tag, ".flush"}, 64'(bus.flush), 64'd0);
        check_val({tag, ".trv"},   64'(bus.tail_restore_valid), 64'd0);
        check_val({tag, ".tail"},  64'(bus.tail_restore), 64'd0);
        check_val({tag, ".head"},  64'(bus.head_ptr), 64'd0);
        check_val({tag, ".halt"},  64'(bus.halted), 64'd0);
        check_val({tag, ".cnt"},   64'(bus.retired_count), 64'd0);
        check_val({tag, ".num"},   64'(bus.num_retiring), 64'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] v, c, m, s, h;
        logic         rdy;
        int           nv, halt_wait;

        do_reset("rst0");

        // Full windows: head advances by 3 each cycle up to 30.
        for (int i = 0; i < 10; i++) cycle(3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 1'b1, "all3", 3);
        check_val("at30.head", 64'(bus.head_ptr), 64'd27);

        // Mispredict at slot 1 with head at 30; tail restore wraps to 0.
        cycle(3'b111, 3'b111, 3'b010, 3'b000, 3'b000, 1'b1, "mis1", 2);
        cycle(3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 1'b1, "flush", 0);
        check_val("flush.pulse", 64'(bus.flush), 64'd1);
        check_val("flush.tail",  64'(bus.tail_restore), 64'd0);
        check_val("flush.head",  64'(bus.head_ptr), 64'd0);
        cycle(3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 1'b1, "rec1", 0);
        cycle(3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 1'b1, "rec2", 0);
        cycle(3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 1'b1, "resume", 3);

        // Stores: only one per cycle, none when the queue is not ready.
        cycle(3'b111, 3'b111, 3'b000, 3'b011, 3'b000, 1'b1, "st2rdy", 1);
        check_val("st2rdy.commit", 64'(bus.store_commit), 64'd1);
        cycle(3'b111, 3'b111, 3'b000, 3'b011, 3'b000, 1'b0, "st2blk", 0);
        cycle(3'b111, 3'b111, 3'b000, 3'b100, 3'b000, 1'b0, "stolder", 2);

        // Incomplete slot in the middle, then partial/empty windows.
        cycle(3'b111, 3'b101, 3'b000, 3'b000, 3'b000, 1'b1, "hole", 1);
        cycle(3'b011, 3'b111, 3'b000, 3'b000, 3'b000, 1'b1, "valid2", 2);
        cycle(3'b000, 3'b111, 3'b111, 3'b111, 3'b111, 1'b1, "empty", 0);

        // Halt at slot 0 beats a mispredict at slot 2.
        cycle(3'b111, 3'b111, 3'b100, 3'b000, 3'b001, 1'b1, "halt0", 1);
        cycle(3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 1'b1, "halted1", 0);
        check_val("halted1.flag",  64'(bus.halted), 64'd1);
        check_val("halted1.flush", 64'(bus.flush), 64'd0);
        cycle(3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 1'b1, "halted2", 0);
        do_reset("rst1");

        // Reset during RECOVER, then normal retirement.
        cycle(3'b111, 3'b111, 3'b001, 3'b000, 3'b000, 1'b1, "mis0", 1);
        cycle(3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 1'b1, "flush0", 0);
        cycle(3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 1'b1, "recA", 0);
        do_reset("rstrec");
        cycle(3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 1'b1, "postrst", 3);

        // Random windows against the model.
        halt_wait = 0;
        for (int t = 0; t < 600; t++) begin
            nv = $urandom_range(0, N);
            v = '0;
            for (int i = 0; i < nv; i++) v[i] = 1'b1;
            c = '0; m = '0; s = '0; h = '0;
            for (int i = 0; i < N; i++) begin
                c[i] = ($urandom_range(0, 3) != 0);
                s[i] = ($urandom_range(0, 2) == 0);
                m[i] = ($urandom_range(0, 7) == 0);
                h[i] = ($urandom_range(0, 29) == 0);
            end
            rdy = ($urandom_range(0, 3) != 0);
            cycle(v, c, m, s, h, rdy, "rnd", -1);
            if (m_halted) begin
                halt_wait++;
                if (halt_wait > 3) begin
                    do_reset("rndrst");
                    halt_wait = 0;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
